// File: rtl/ready_list_pq.sv
// ready_list_pq
//   Hardware ready-list for the task scheduler. One circular doubly-linked list
//   of task IDs per priority level, with insert, remove and round-robin get of
//   the highest-priority ready task. Each task's priority is stored on insert,
//   so remove only needs the task ID.
//
//   Optional feature macro: READY_LIST_PEEK_EN
//     defined   : op 11 = PEEK (GET without advancing the list head)
//     undefined : op 11 is rejected with err_o=1
//
//   Ports
//     clk_i    clock
//     rst_i    synchronous active-high reset
//     req_i    command strobe, taken only while ready_o=1
//     op_i     00=GET 01=INSERT 10=REMOVE 11=PEEK
//     tid_i    task ID for INSERT/REMOVE
//     pri_i    priority for INSERT
//     ready_o  idle, can accept a command
//     done_o   one-cycle completion pulse
//     err_o    command rejected (qualified by done_o)
//     tid_o    result task ID, all-ones = none
//     pri_o    priority of tid_o
//     empty_o  no task listed
//     count_o  number of listed tasks
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a command; decodes and validates it
//   GET1  | present head of highest list, advance head (GET only)
//   INS0  | insert into an empty list
//   INS1  | insert: capture old head (new next) and old tail (new prev)
//   INS2  | insert: link old tail and old head to the new task
//   INS3  | insert: link the new task, mark it listed
//   REM1  | remove: capture neighbours of the task
//   REM2  | remove: clear list valid if sole member, else relink prev
//   REM3  | remove: relink next, move head if needed, unmark task
//   ERR   | rejected command, report err_o
module ready_list_pq #(
    parameter int NTASKS = 32,
    parameter int NPRI   = 8,
    parameter int TIDW   = $clog2(NTASKS),
    parameter int PRIW   = (NPRI > 1) ? $clog2(NPRI) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic [1:0]      op_i,
    input  logic [TIDW-1:0] tid_i,
    input  logic [PRIW-1:0] pri_i,
    output logic            ready_o,
    output logic            done_o,
    output logic            err_o,
    output logic [TIDW:0]   tid_o,
    output logic [PRIW-1:0] pri_o,
    output logic            empty_o,
    output logic [TIDW:0]   count_o
);

    localparam logic [1:0]    OP_GET    = 2'b00;
    localparam logic [1:0]    OP_INSERT = 2'b01;
    localparam logic [1:0]    OP_REMOVE = 2'b10;
    localparam logic [TIDW:0] TID_NONE  = '1;
    localparam logic [TIDW:0] CNT_ONE   = {{TIDW{1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        IDLE, GET1, INS0, INS1, INS2, INS3, REM1, REM2, REM3, ERR
    } state_t;

    state_t state_q, state_d;

    logic [TIDW-1:0]   nxt_q  [NTASKS];
    logic [TIDW-1:0]   prv_q  [NTASKS];
    logic [PRIW-1:0]   tpri_q [NTASKS];
    logic [TIDW-1:0]   head_q [NPRI];
    logic [NTASKS-1:0] in_list_q, in_list_d;
    logic [NPRI-1:0]   headv_q, headv_d;

    // Command context. nx/pv are the neighbours of tid: for INSERT they become
    // its next (old head) and prev (old tail); for REMOVE they are read out.
    logic [TIDW-1:0] tid_q, tid_d;
    logic [PRIW-1:0] p_q, p_d;
    logic [TIDW-1:0] nx_q, nx_d;
    logic [TIDW-1:0] pv_q, pv_d;
    logic            get_none_q, get_none_d;
    logic            peek_q, peek_d;

    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [TIDW:0]   tid_res_q, tid_res_d;
    logic [PRIW-1:0] pri_res_q, pri_res_d;
    logic [TIDW:0]   count_q, count_d;
    logic            empty_q, empty_d;

    logic            nxt_we, prv_we, head_we, tpri_we;
    logic [TIDW-1:0] nxt_wa, nxt_wd, prv_wa, prv_wd, head_wd;
    logic [PRIW-1:0] head_wa;

    logic [PRIW-1:0] hi_pri;
    logic            pri_ok;

    assign pri_ok = (32'(pri_i) < NPRI);

    always_comb begin
        hi_pri = '0;
        for (int i = 0; i < NPRI; i++) begin
            if (headv_q[i]) hi_pri = PRIW'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        tid_d      = tid_q;
        p_d        = p_q;
        nx_d       = nx_q;
        pv_d       = pv_q;
        get_none_d = get_none_q;
        peek_d     = peek_q;
        in_list_d  = in_list_q;
        headv_d    = headv_q;
        count_d    = count_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        tid_res_d  = tid_res_q;
        pri_res_d  = pri_res_q;
        nxt_we     = 1'b0;
        nxt_wa     = tid_q;
        nxt_wd     = tid_q;
        prv_we     = 1'b0;
        prv_wa     = tid_q;
        prv_wd     = tid_q;
        head_we    = 1'b0;
        head_wa    = p_q;
        head_wd    = tid_q;
        tpri_we    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    case (op_i)
                        OP_GET: begin
                            p_d        = hi_pri;
                            get_none_d = (headv_q == '0);
                            peek_d     = 1'b0;
                            state_d    = GET1;
                        end
                        OP_INSERT: begin
                            tid_d = tid_i;
                            p_d   = pri_i;
                            if (!pri_ok || in_list_q[tid_i]) state_d = ERR;
                            else if (headv_q[pri_i])         state_d = INS1;
                            else                             state_d = INS0;
                        end
                        OP_REMOVE: begin
                            tid_d   = tid_i;
                            p_d     = tpri_q[tid_i];
                            state_d = in_list_q[tid_i] ? REM1 : ERR;
                        end
                        default: begin
`ifdef READY_LIST_PEEK_EN
                            p_d        = hi_pri;
                            get_none_d = (headv_q == '0);
                            peek_d     = 1'b1;
                            state_d    = GET1;
`else
                            state_d    = ERR;
`endif
                        end
                    endcase
                end
            end
            GET1: begin
                done_d = 1'b1;
                if (get_none_q) begin
                    tid_res_d = TID_NONE;
                    pri_res_d = '0;
                end else begin
                    tid_res_d = {1'b0, head_q[p_q]};
                    pri_res_d = p_q;
                    head_we   = !peek_q;
                    head_wd   = nxt_q[head_q[p_q]];
                end
                state_d = IDLE;
            end
            INS0: begin
                head_we        = 1'b1;
                headv_d[p_q]   = 1'b1;
                nxt_we         = 1'b1;
                prv_we         = 1'b1;
                in_list_d[tid_q] = 1'b1;
                tpri_we        = 1'b1;
                count_d        = count_q + CNT_ONE;
                done_d         = 1'b1;
                state_d        = IDLE;
            end
            INS1: begin
                nx_d    = head_q[p_q];
                pv_d    = prv_q[head_q[p_q]];
                state_d = INS2;
            end
            INS2: begin
                prv_we  = 1'b1;
                prv_wa  = nx_q;
                nxt_we  = 1'b1;
                nxt_wa  = pv_q;
                state_d = INS3;
            end
            INS3: begin
                nxt_we           = 1'b1;
                nxt_wd           = nx_q;
                prv_we           = 1'b1;
                prv_wd           = pv_q;
                in_list_d[tid_q] = 1'b1;
                tpri_we          = 1'b1;
                count_d          = count_q + CNT_ONE;
                done_d           = 1'b1;
                state_d          = IDLE;
            end
            REM1: begin
                nx_d    = nxt_q[tid_q];
                pv_d    = prv_q[tid_q];
                state_d = REM2;
            end
            REM2: begin
                if (nx_q == tid_q) begin
                    headv_d[p_q] = 1'b0;
                end else begin
                    prv_we = 1'b1;
                    prv_wa = nx_q;
                    prv_wd = pv_q;
                end
                state_d = REM3;
            end
            REM3: begin
                // For a sole member this rewrites nxt[tid]=tid, which is harmless.
                nxt_we           = 1'b1;
                nxt_wa           = pv_q;
                nxt_wd           = nx_q;
                head_we          = (head_q[p_q] == tid_q);
                head_wd          = nx_q;
                in_list_d[tid_q] = 1'b0;
                count_d          = count_q - CNT_ONE;
                done_d           = 1'b1;
                state_d          = IDLE;
            end
            ERR: begin
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            in_list_q  <= '0;
            headv_q    <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tid_res_q  <= TID_NONE;
            pri_res_q  <= '0;
            tid_q      <= '0;
            p_q        <= '0;
            nx_q       <= '0;
            pv_q       <= '0;
            get_none_q <= 1'b0;
            peek_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_list_q  <= in_list_d;
            headv_q    <= headv_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tid_res_q  <= tid_res_d;
            pri_res_q  <= pri_res_d;
            tid_q      <= tid_d;
            p_q        <= p_d;
            nx_q       <= nx_d;
            pv_q       <= pv_d;
            get_none_q <= get_none_d;
            peek_q     <= peek_d;
        end
    end

    // Link storage is deliberately not reset; in_list/headv gate its validity.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (nxt_we)  nxt_q[nxt_wa]   <= nxt_wd;
            if (prv_we)  prv_q[prv_wa]   <= prv_wd;
            if (head_we) head_q[head_wa] <= head_wd;
            if (tpri_we) tpri_q[tid_q]   <= p_q;
        end
    end

    assign ready_o = (state_q == IDLE) && !rst_i;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign tid_o   = tid_res_q;
    assign pri_o   = pri_res_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_ready_list_pq.sv
// Directed bench for ready_list_pq with default parameters (32 tasks, 8 levels).
// Stimulus pushes hand-computed expectations into a queue; a monitor pops and
// compares on every done_o pulse.
module tb_ready_list_pq;

    localparam int TIDW = 5;
    localparam int PRIW = 3;
    localparam int NONE = 63;
    localparam logic [1:0] GET = 2'b00, INS = 2'b01, REM = 2'b10, PEEK = 2'b11;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            req_i = 1'b0;
    logic [1:0]      op_i  = 2'b00;
    logic [TIDW-1:0] tid_i = '0;
    logic [PRIW-1:0] pri_i = '0;
    logic            ready_o, done_o, err_o, empty_o;
    logic [TIDW:0]   tid_o, count_o;
    logic [PRIW-1:0] pri_o;

    ready_list_pq dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .op_i(op_i),
        .tid_i(tid_i), .pri_i(pri_i), .ready_o(ready_o), .done_o(done_o),
        .err_o(err_o), .tid_o(tid_o), .pri_o(pri_o), .empty_o(empty_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        string name;
        logic  exp_err;
        logic  chk_tid;
        int    exp_tid;
        int    exp_pri;
        int    exp_count;
        int    exp_lat;
        int    issue;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout", name);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        exp_t e;
        if (done_o) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done_o=1 expected none at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_err"},   32'(err_o),   32'(e.exp_err));
                check({e.name, "_count"}, 32'(count_o), e.exp_count);
                check({e.name, "_empty"}, 32'(empty_o), 32'(e.exp_count == 0));
                check({e.name, "_lat"},   cyc - e.issue, e.exp_lat);
                if (e.chk_tid) begin
                    check({e.name, "_tid"}, 32'(tid_o), e.exp_tid);
                    if (e.exp_tid != NONE) check({e.name, "_pri"}, 32'(pri_o), e.exp_pri);
                end
            end
        end else if (err_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL err_without_done: got err_o=1 expected 0 at cycle %0d", cyc);
        end
    end

    task automatic wait_ready(input string name, output logic ok);
        int budget = 0;
        while (!ready_o && budget < 50) begin
            @(negedge clk_i);
            budget++;
        end
        ok = ready_o;
        if (!ok) fail_now({name, "_ready"});
    endtask

    task automatic cmd(input string name, input logic [1:0] op, input int tid, input int pri,
                       input logic exp_err, input logic chk_tid, input int exp_tid,
                       input int exp_pri, input int exp_count, input int exp_lat);
        exp_t e;
        logic ok;
        wait_ready(name, ok);
        if (!ok) return;
        e.name = name; e.exp_err = exp_err; e.chk_tid = chk_tid; e.exp_tid = exp_tid;
        e.exp_pri = exp_pri; e.exp_count = exp_count; e.exp_lat = exp_lat; e.issue = cyc;
        sb.push_back(e);
        req_i = 1'b1;
        op_i  = op;
        tid_i = TIDW'(tid);
        pri_i = PRIW'(pri);
        @(negedge clk_i);
        req_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int budget = 0;
        while (sb.size() != 0 && budget < 50) begin
            @(negedge clk_i);
            budget++;
        end
        if (sb.size() != 0) begin
            fail_now({name, "_drain"});
            sb.delete();
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        logic ok;
        @(negedge clk_i);
        do_reset();
        check("rst_ready", 32'(ready_o), 1);
        check("rst_done",  32'(done_o),  0);
        check("rst_err",   32'(err_o),   0);
        check("rst_tid",   32'(tid_o),   NONE);
        check("rst_pri",   32'(pri_o),   0);
        check("rst_empty", 32'(empty_o), 1);
        check("rst_count", 32'(count_o), 0);

        // Empty get, then round-robin across two levels.
        cmd("get_empty", GET, 0, 0, 0, 1, NONE, 0, 0, 2);
        cmd("ins5p2",    INS, 5, 2, 0, 0, 0, 0, 1, 2);
        cmd("ins9p2",    INS, 9, 2, 0, 0, 0, 0, 2, 4);
        cmd("ins3p6",    INS, 3, 6, 0, 0, 0, 0, 3, 2);
        cmd("get_a",     GET, 0, 0, 0, 1, 3, 6, 3, 2);
        cmd("get_b",     GET, 0, 0, 0, 1, 3, 6, 3, 2);
        cmd("get_c",     GET, 0, 0, 0, 1, 3, 6, 3, 2);
        cmd("rem3",      REM, 3, 0, 0, 0, 0, 0, 2, 4);
        cmd("rr_a",      GET, 0, 0, 0, 1, 5, 2, 2, 2);
        cmd("rr_b",      GET, 0, 0, 0, 1, 9, 2, 2, 2);
        cmd("rr_c",      GET, 0, 0, 0, 1, 5, 2, 2, 2);
        drain("rr");

        // Duplicate insert and absent remove.
        do_reset();
        cmd("dup_first", INS, 5, 1, 0, 0, 0, 0, 1, 2);
        cmd("dup_again", INS, 5, 1, 1, 0, 0, 0, 1, 2);
        cmd("rem_absent", REM, 7, 0, 1, 0, 0, 0, 1, 2);
        cmd("rem5_sole", REM, 5, 0, 0, 0, 0, 0, 0, 4);
        drain("dup");

        // Head removal and emptying a three-member list.
        cmd("ins1p4",   INS, 1, 4, 0, 0, 0, 0, 1, 2);
        cmd("ins2p4",   INS, 2, 4, 0, 0, 0, 0, 2, 4);
        cmd("ins3p4",   INS, 3, 4, 0, 0, 0, 0, 3, 4);
        cmd("rem1head", REM, 1, 0, 0, 0, 0, 0, 2, 4);
        cmd("get_p4",   GET, 0, 0, 0, 1, 2, 4, 2, 2);
        cmd("rem3p4",   REM, 3, 0, 0, 0, 0, 0, 1, 4);
        cmd("rem2p4",   REM, 2, 0, 0, 0, 0, 0, 0, 4);
        cmd("get_gone", GET, 0, 0, 0, 1, NONE, 0, 0, 2);
        drain("p4");

        // Reset while an insert sits in INS2.
        cmd("ins7p3", INS, 7, 3, 0, 0, 0, 0, 1, 2);
        drain("pre_abort");
        wait_ready("abort", ok);
        req_i = 1'b1; op_i = INS; tid_i = TIDW'(8); pri_i = PRIW'(3);
        @(negedge clk_i);
        req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("abort_ready_in_rst", 32'(ready_o), 0);
        check("abort_done_in_rst",  32'(done_o),  0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("abort_ready_after", 32'(ready_o), 1);
        check("abort_count",       32'(count_o), 0);
        check("abort_empty",       32'(empty_o), 1);
        cmd("abort_get",  GET, 0, 0, 0, 1, NONE, 0, 0, 2);
        cmd("abort_ins8", INS, 8, 3, 0, 0, 0, 0, 1, 2);
        drain("abort");

        // Op 11.
        do_reset();
        cmd("ins4p0", INS, 4, 0, 0, 0, 0, 0, 1, 2);
        cmd("ins6p0", INS, 6, 0, 0, 0, 0, 0, 2, 4);
`ifdef READY_LIST_PEEK_EN
        cmd("peek_a", PEEK, 0, 0, 0, 1, 4, 0, 2, 2);
        cmd("peek_b", PEEK, 0, 0, 0, 1, 4, 0, 2, 2);
        cmd("get_4",  GET,  0, 0, 0, 1, 4, 0, 2, 2);
        cmd("peek_c", PEEK, 0, 0, 0, 1, 6, 0, 2, 2);
`else
        cmd("get_4",   GET,  0, 0, 0, 1, 4, 0, 2, 2);
        cmd("op11_err", PEEK, 0, 0, 1, 1, 4, 0, 2, 2);
        cmd("get_6",   GET,  0, 0, 0, 1, 6, 0, 2, 2);
`endif
        drain("op11");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ready_list_pq.md
Name: ready_list_pq

Overview:
- Parametrised hardware ready-list for the task scheduler. Keeps one circular doubly-linked list of task IDs per priority level.
- Supports insert, remove and round-robin get of the highest-priority ready task.
- Next-generation replacement for the fixed 16-task/5-level ready list. Adds:
  - configurable task count and priority levels;
  - a stored per-task priority, so remove needs no priority input;
  - an automatic highest-priority search;
  - explicit error reporting.

Parameters:
- NTASKS, 32, number of task slots; power of two, 4..256.
- NPRI, 8, number of priority levels; level NPRI-1 is highest.
- TIDW, $clog2(NTASKS), task-ID width.
- PRIW, $clog2(NPRI) (minimum 1), priority width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  command strobe; accepted only when ready_o=1
- op_i  in  2  00=GET, 01=INSERT, 10=REMOVE, 11=PEEK (optional)
- tid_i  in  TIDW  task ID for INSERT/REMOVE
- pri_i  in  PRIW  priority for INSERT; ignored otherwise
- ready_o  out  1  block idle, can accept req_i
- done_o  out  1  one-cycle pulse at command completion
- err_o  out  1  valid with done_o; command rejected
- tid_o  out  TIDW+1  result task ID; all-ones = none
- pri_o  out  PRIW  priority of tid_o
- empty_o  out  1  no task in any list
- count_o  out  TIDW+1  total tasks in list

Behaviour:
- Storage: nxt[NTASKS], prv[NTASKS], tpri[NTASKS], in_list[NTASKS], head[NPRI], headv[NPRI].
- ready_o = (state==IDLE) && !rst_i. req_i is ignored when ready_o=0.
- Reset (any state, mid-command included):
  - state=IDLE; in_list=0, headv=0, count_o=0;
  - done_o=0, err_o=0, tid_o=all-ones, pri_o=0, empty_o=1.
  - Any in-flight command is abandoned without a done pulse. Link arrays are not reset.
- GET, 2 cycles (IDLE -> GET1 -> IDLE, done_o in cycle 2):
  - IDLE latches p = highest set bit of headv.
  - GET1 sets tid_o=head[p], pri_o=p, then head[p]<=nxt[head[p]] (round-robin advance; the task stays listed).
  - If headv==0: done_o pulses next cycle with tid_o=all-ones and err_o=0. There is no error for an empty get.
- INSERT, appends at the tail of list pri_i:
  - Already listed: err_o=1 with done_o in the next cycle; no state change.
  - List empty (INS0): head=tid, headv=1, nxt[tid]=prv[tid]=tid. 2 cycles.
  - List non-empty (INS1 -> INS2 -> INS3): t=prv[head]; prv[head]=tid; nxt[t]=tid; nxt[tid]=head; prv[tid]=t. 4 cycles total.
  - Completion sets in_list[tid]=1, tpri[tid]=pri_i and count+1.
- REMOVE, priority taken from tpri[tid_i]:
  - Not listed: err_o=1 with done_o in the next cycle; no state change.
  - REM1: latch nx=nxt[tid], pv=prv[tid].
  - REM2: if nx==tid (sole member), headv[p]=0; otherwise prv[nx]=pv.
  - REM3: nxt[pv]=nx; if head[p]==tid then head[p]=nx; in_list[tid]=0; count-1; done_o.
  - 4 cycles total.
- At most one command in flight; there is no simultaneous-command case.
- tid_o and pri_o hold their value until the next GET/PEEK completes. err_o is 0 whenever done_o=0.
- empty_o = (count_o==0), registered and updated on the same cycle as count.
- Arithmetic: count_o never wraps. It is bounded by NTASKS because duplicates are rejected.
- tid_i ≥ NTASKS is impossible by width. pri_i ≥ NPRI on INSERT gives err_o=1.

Optional Feature:
- Macro READY_LIST_PEEK_EN.
- Defined: op 11 = PEEK. Same result and timing as GET, but head is not advanced.
- Undefined: op 11 completes in 2 cycles with err_o=1, tid_o unchanged, no state change.

Test Plan:
- Reset, then GET -> done_o after 2 cycles, tid_o=all-ones, err_o=0, empty_o=1, count_o=0.
- INSERT 5@p2, 9@p2, 3@p6, then GET×3 -> tid_o=3,3,3 with pri_o=6. REMOVE 3, then GET×3 -> tid_o=5,9,5 (round-robin).
- INSERT 5@p1 twice -> second returns err_o=1, count_o=1. REMOVE 7 (absent) -> err_o=1, count unchanged.
- List p4 = {1,2,3}: REMOVE 1 (head) -> next GET returns 2. REMOVE 3, then REMOVE 2 -> headv[4]=0, empty_o=1.
- Assert rst_i during INS2 of an insert -> no done_o, ready_o=1 the cycle after reset drops, GET returns all-ones.
- With READY_LIST_PEEK_EN: INSERT 4,6@p0, PEEK×2 -> 4,4, then GET -> 4, PEEK -> 6. Without the macro: op 11 -> err_o=1.
